// File: rtl/pwr_clk_ctrl.sv
// Always-on power/clock controller: sequences the main clock gate and the
// low-speed oscillator around sleep entry/exit, with a watchdog on aon_clk.
module pwr_clk_ctrl #(
  parameter int LSI_SETTLE  = 4,
  parameter int WAKE_SETTLE = 2,
  parameter int DRAIN_MAX   = 8,
  parameter int WDT_TIMEOUT = 16
) (
  input  logic       aon_clk,
  input  logic       reset,
  input  logic       sleep_req,
  input  logic       busy,
  input  logic       wake_evt,
  input  logic       wdt_kick,
  input  logic       wdt_clear,
  output logic       clk_enable,
  output logic       lsi_enable,
  output logic [1:0] mode,
  output logic       sleep_ack,
  output logic       sleep_abort,
  output logic       wdt_expire,
  output logic       wdt_flag
);

  localparam int MAXP = (LSI_SETTLE > WAKE_SETTLE) ?
                        ((LSI_SETTLE > DRAIN_MAX) ? LSI_SETTLE : DRAIN_MAX) :
                        ((WAKE_SETTLE > DRAIN_MAX) ? WAKE_SETTLE : DRAIN_MAX);
  localparam int CW = $clog2(MAXP) + 1;
  localparam int WW = (WDT_TIMEOUT > 2) ? $clog2(WDT_TIMEOUT) : 1;

  localparam logic [CW-1:0] LSI_LAST   = CW'(LSI_SETTLE - 1);
  localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_SETTLE - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);
  localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_TIMEOUT - 1);

  typedef enum logic [2:0] {RUN, DRAIN, LSI_START, SLEEP, WAKE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wdt_cnt;
  logic          abort_nxt, expire_nxt, wdt_run, give_up;

  always_comb begin
    state_nxt  = state;
    abort_nxt  = 1'b0;
    wdt_run    = (state != SLEEP);
    expire_nxt = wdt_run && !wdt_kick && (wdt_cnt == WDT_LAST);
    give_up    = !sleep_req || wake_evt;
    case (state)
      RUN:       if (sleep_req) state_nxt = DRAIN;
      DRAIN: begin
        if (give_up) begin
          state_nxt = RUN;
          abort_nxt = 1'b1;
        end else if (!busy) begin
          state_nxt = LSI_START;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = RUN;
          abort_nxt = 1'b1;
        end
      end
      LSI_START: begin
        if (give_up) begin
          state_nxt = RUN;
          abort_nxt = 1'b1;
        end else if (cnt == LSI_LAST) begin
          state_nxt = SLEEP;
        end
      end
      SLEEP:     if (wake_evt) state_nxt = WAKE;
      WAKE:      if (cnt == WAKE_LAST) state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
    // expiry only happens outside SLEEP, so it overrides every live transition
    if (expire_nxt) begin
      abort_nxt = (state == DRAIN) || (state == LSI_START);
      state_nxt = RUN;
    end
  end

  always_ff @(posedge aon_clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge aon_clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt    <= '0;
      wdt_expire <= 1'b0;
      wdt_flag   <= 1'b0;
    end else begin
      wdt_expire <= expire_nxt;
      wdt_flag   <= expire_nxt | (wdt_flag & ~wdt_clear);
      if (wdt_kick || expire_nxt) wdt_cnt <= '0;
      else if (wdt_run)           wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge aon_clk or negedge reset) begin
    if (!reset) begin
      clk_enable  <= 1'b0;
      lsi_enable  <= 1'b0;
      mode        <= 2'd0;
      sleep_ack   <= 1'b0;
      sleep_abort <= 1'b0;
    end else begin
      clk_enable  <= (state_nxt != SLEEP);
      lsi_enable  <= (state_nxt == LSI_START) || (state_nxt == SLEEP) || (state_nxt == WAKE);
      sleep_ack   <= (state_nxt == SLEEP);
      sleep_abort <= abort_nxt;
      case (state_nxt)
        RUN:             mode <= 2'd0;
        DRAIN, LSI_START: mode <= 2'd1;
        SLEEP:           mode <= 2'd2;
        default:         mode <= 2'd3;
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_clk_ctrl.sv
// Directed bench for pwr_clk_ctrl: a vector table for the sleep/wake/abort
// flows plus hand sequences for the watchdog and asynchronous reset.
module tb_pwr_clk_ctrl;

  logic       aon_clk = 1'b0;
  logic       reset, sleep_req, busy, wake_evt, wdt_kick, wdt_clear;
  logic       clk_enable, lsi_enable, sleep_ack, sleep_abort, wdt_expire, wdt_flag;
  logic [1:0] mode;
  logic [7:0] obs;

  pwr_clk_ctrl dut (
    .aon_clk(aon_clk), .reset(reset), .sleep_req(sleep_req), .busy(busy),
    .wake_evt(wake_evt), .wdt_kick(wdt_kick), .wdt_clear(wdt_clear),
    .clk_enable(clk_enable), .lsi_enable(lsi_enable), .mode(mode),
    .sleep_ack(sleep_ack), .sleep_abort(sleep_abort),
    .wdt_expire(wdt_expire), .wdt_flag(wdt_flag)
  );

  always #5 aon_clk = ~aon_clk;

  // {clk_enable, lsi_enable, mode, sleep_ack, sleep_abort, wdt_expire, wdt_flag}
  assign obs = {clk_enable, lsi_enable, mode, sleep_ack, sleep_abort, wdt_expire, wdt_flag};

  localparam logic [7:0] O_RST = 8'h00, O_RUN = 8'h80, O_ABT = 8'h84, O_DRN = 8'h90,
                         O_LSI = 8'hD0, O_SLP = 8'h68, O_WAK = 8'hF0;

  typedef struct {
    logic       sr, bz, wk, kk, cl;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic sr, logic bz, logic wk, logic kk, logic cl, logic [7:0] exp);
    vec_t v;
    v.sr = sr; v.bz = bz; v.wk = wk; v.kk = kk; v.cl = cl; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (ce,le,mode,ack,abort,expire,flag)", nm, obs, exp);
    end
  endtask

  task automatic step(input logic sr, input logic bz, input logic wk, input logic kk, input logic cl);
    sleep_req = sr; busy = bz; wake_evt = wk; wdt_kick = kk; wdt_clear = cl;
    @(posedge aon_clk);
    #1;
  endtask

  task automatic do_reset();
    sleep_req = 0; busy = 0; wake_evt = 0; wdt_kick = 0; wdt_clear = 0;
    reset = 1'b0;
    #2;
    chk("reset_state", O_RST);
    @(posedge aon_clk);
    #1;
    reset = 1'b1;
    chk("reset_release", O_RST);
  endtask

  initial begin
    // Sleep entry, sleep, wake, LSI-phase abort, drain timeout, re-drain; kicks keep the watchdog quiet.
    tbl.push_back(mk(1,0,0,1,0, O_DRN));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,1,0, O_LSI));
    tbl.push_back(mk(1,0,0,1,0, O_SLP));
    tbl.push_back(mk(1,0,0,1,0, O_SLP));
    tbl.push_back(mk(0,0,0,1,0, O_SLP));
    tbl.push_back(mk(0,0,1,1,0, O_WAK));
    tbl.push_back(mk(0,0,0,1,0, O_WAK));
    tbl.push_back(mk(0,0,0,1,0, O_RUN));
    tbl.push_back(mk(0,0,0,1,0, O_RUN));
    tbl.push_back(mk(1,0,0,1,0, O_DRN));
    tbl.push_back(mk(1,0,0,1,0, O_LSI));
    tbl.push_back(mk(1,0,0,1,0, O_LSI));
    tbl.push_back(mk(1,0,1,1,0, O_ABT));
    tbl.push_back(mk(0,0,0,1,0, O_RUN));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1,1,0,1,0, O_DRN));
    tbl.push_back(mk(1,1,0,1,0, O_ABT));
    tbl.push_back(mk(1,1,0,1,0, O_DRN));
    tbl.push_back(mk(0,1,0,1,0, O_ABT));
    tbl.push_back(mk(0,0,0,1,0, O_RUN));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].sr, tbl[i].bz, tbl[i].wk, tbl[i].kk, tbl[i].cl);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Watchdog in RUN: expiry on the 16th edge, clear collides with expiry, then clear.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step(0,0,0,0,0);
      chk($sformatf("wdt_pre%0d", i), O_RUN);
    end
    step(0,0,0,0,1);
    chk("wdt_expire_vs_clear", 8'h83);
    step(0,0,0,0,0);
    chk("wdt_flag_sticky", 8'h81);
    step(0,0,0,0,1);
    chk("wdt_flag_clear", O_RUN);
    for (int i = 0; i < 40; i++) begin
      step(0,0,0,(i % 10 == 0),0);
      chk($sformatf("wdt_kick10_%0d", i), O_RUN);
    end
    for (int i = 0; i < 6; i++) step(0,0,0,0,0);
    step(0,0,0,1,0);
    chk("wdt_kick_beats_expiry", O_RUN);
    step(0,0,0,0,0);
    chk("wdt_after_kick", O_RUN);

    // Expiry while draining forces RUN with an abort; sleep_req still high re-enters DRAIN.
    do_reset();
    for (int i = 0; i < 15; i++) step(1,1,0,0,0);
    step(1,1,0,0,0);
    chk("wdt_expire_in_drain", 8'h87);
    step(1,1,0,0,0);
    chk("redrain_after_expiry", 8'h91);

    // Watchdog holds in SLEEP; async reset in SLEEP drops everything at once.
    do_reset();
    for (int i = 0; i < 6; i++) step(1,0,0,0,0);
    chk("sleep_entry_nokick", O_SLP);
    for (int i = 0; i < 20; i++) begin
      step(0,0,0,0,0);
      chk($sformatf("sleep_wdt_hold%0d", i), O_SLP);
    end
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_in_sleep", O_RST);
    @(posedge aon_clk);
    #1;
    reset = 1'b1;
    step(0,0,0,0,0);
    chk("first_edge_clk_on", O_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
